// File: rtl/input_pkg.sv
// Shared definitions for the push-button front end: per-button FSM state
// encodings and the default debounce/repeat counts.
package input_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    WQ      = 3'd1,
    SCEN_ST = 3'd2,
    HOLD    = 3'd3,
    MCEN_ST = 3'd4,
    WFCR    = 3'd5
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_MCEN_DELAY      = 50_000_000;
  localparam int DEF_MCEN_PERIOD     = 10_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_debounce_fsm.sv
// One button: 2-flop synchronizer, shared debounce/repeat counter, repeat flag
// and a Moore FSM producing the level, single, multiple and continuous enables.
module button_debounce_fsm
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MCEN_DELAY      = DEF_MCEN_DELAY,
  parameter int MCEN_PERIOD     = DEF_MCEN_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic dpb_o,
  output logic scen_o,
  output logic mcen_o,
  output logic ccen_o
);

  // Counter only ever reaches (largest count - 1) before being cleared.
  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, MCEN_DELAY, MCEN_PERIOD);
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(MCEN_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(MCEN_PERIOD - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rep_q, rep_d;
  logic [CNT_W-1:0] hold_last;

  assign btn_s     = sync_q[1];
  assign hold_last = rep_q ? PER_LAST : DLY_LAST;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b00;
      state_q <= INIT;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    dpb_o   = 1'b0;
    scen_o  = 1'b0;
    mcen_o  = 1'b0;
    ccen_o  = 1'b0;
    unique case (state_q)
      INIT: begin
        if (btn_s) begin
          state_d = WQ;
          cnt_d   = '0;
        end
      end
      WQ: begin
        if (!btn_s)                state_d = INIT;
        else if (cnt_q == DEB_LAST) state_d = SCEN_ST;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      SCEN_ST: begin
        scen_o  = 1'b1;
        mcen_o  = 1'b1;
        dpb_o   = 1'b1;
        ccen_o  = 1'b1;
        state_d = HOLD;
        cnt_d   = '0;
        rep_d   = 1'b0;
      end
      HOLD: begin
        dpb_o  = 1'b1;
        ccen_o = 1'b1;
        if (!btn_s) begin
          state_d = WFCR;
          cnt_d   = '0;
        end else if (cnt_q == hold_last) begin
          state_d = MCEN_ST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MCEN_ST: begin
        mcen_o  = 1'b1;
        dpb_o   = 1'b1;
        ccen_o  = 1'b1;
        rep_d   = 1'b1;
        state_d = HOLD;
        cnt_d   = '0;
      end
      WFCR: begin
        // A return to high resumes holding without a fresh press; rep survives.
        dpb_o  = 1'b1;
        ccen_o = 1'b1;
        if (btn_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = INIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BTN raw push-buttons and produces per-button level, single,
// repeating and continuous enables for the game logic.
module button_debouncer
  import input_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MCEN_DELAY      = DEF_MCEN_DELAY,
  parameter int MCEN_PERIOD     = DEF_MCEN_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] buttons,
  output logic [N_BTN-1:0] DPBs,
  output logic [N_BTN-1:0] SCENs,
  output logic [N_BTN-1:0] MCENs,
  output logic [N_BTN-1:0] CCENs
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .MCEN_DELAY     (MCEN_DELAY),
      .MCEN_PERIOD    (MCEN_PERIOD)
    ) u_fsm (
      .clk   (clk),
      .reset (reset),
      .btn_i (buttons[i]),
      .dpb_o (DPBs[i]),
      .scen_o(SCENs[i]),
      .mcen_o(MCENs[i]),
      .ccen_o(CCENs[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with short counts; expected pulses and
// levels are queued by the stimulus and checked by an independent monitor.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] buttons = 4'b0000;
  logic [3:0] DPBs, SCENs, MCENs, CCENs;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] scen;
    logic [3:0] mcen;
  } pulse_t;

  typedef struct {
    int         cyc;
    logic [3:0] lvl;
  } lvl_t;

  pulse_t pq[$];
  lvl_t   lq[$];

  button_debouncer #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(4),
    .MCEN_DELAY     (8),
    .MCEN_PERIOD    (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .buttons(buttons),
    .DPBs   (DPBs),
    .SCENs  (SCENs),
    .MCENs  (MCENs),
    .CCENs  (CCENs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic push_pulse(input int c, input logic [3:0] s, input logic [3:0] m);
    pulse_t p;
    p.cyc = c; p.scen = s; p.mcen = m;
    pq.push_back(p);
  endtask

  task automatic push_lvl(input int c, input logic [3:0] v);
    lvl_t l;
    l.cyc = c; l.lvl = v;
    lq.push_back(l);
  endtask

  task automatic at_neg(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Monitor: cycle k is the output observed after posedge k.
  always @(negedge clk) begin
    if (cyc > 0 && !done) begin
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_pulse cyc=%0d actual=none required=scen %b mcen %b at %0d",
                 cyc, pq[0].scen, pq[0].mcen, pq[0].cyc);
        void'(pq.pop_front());
      end
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        chk("scen", SCENs, pq[0].scen);
        chk("mcen", MCENs, pq[0].mcen);
        void'(pq.pop_front());
      end else if ((SCENs | MCENs) != 4'b0000) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d actual=scen %b mcen %b required=0000",
                 cyc, SCENs, MCENs);
      end
      while (lq.size() > 0 && lq[0].cyc <= cyc) begin
        if (lq[0].cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL stale_level cyc=%0d actual=skipped required=%b", lq[0].cyc, lq[0].lvl);
        end else begin
          chk("dpb", DPBs, lq[0].lvl);
          chk("ccen", CCENs, lq[0].lvl);
        end
        void'(lq.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] tog [4];
    tog[0] = 4'b0101; tog[1] = 4'b1010; tog[2] = 4'b1111; tog[3] = 4'b0011;

    // Reset held with buttons toggling: everything stays 0.
    for (int c = 1; c <= 8; c++) push_lvl(c, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      at_neg(k + 1);
      buttons = tog[k];
    end
    at_neg(5);
    reset   = 1'b0;
    buttons = 4'b0000;

    // Clean press on bit 2 sampled from edge 10, held 40 samples.
    at_neg(9);
    push_lvl(15, 4'b0000);
    push_lvl(16, 4'b0100);
    push_lvl(55, 4'b0100);
    push_lvl(56, 4'b0000);
    push_pulse(16, 4'b0100, 4'b0100);
    for (int c = 25; c <= 49; c += 4) push_pulse(c, 4'b0000, 4'b0100);
    buttons = 4'b0100;
    at_neg(49);
    buttons = 4'b0000;

    // Bounce on bit 0: high 3, low 1, high 2, then low.
    at_neg(59);
    for (int c = 61; c <= 72; c++) push_lvl(c, 4'b0000);
    buttons = 4'b0001;
    at_neg(62);
    buttons = 4'b0000;
    at_neg(63);
    buttons = 4'b0001;
    at_neg(65);
    buttons = 4'b0000;

    // Bit 1 held with a 2-sample low glitch before the first repeat.
    at_neg(79);
    push_lvl(85, 4'b0000);
    push_lvl(86, 4'b0010);
    for (int c = 90; c <= 96; c++) push_lvl(c, 4'b0010);
    push_lvl(117, 4'b0010);
    push_lvl(118, 4'b0000);
    push_pulse(86, 4'b0010, 4'b0010);
    push_pulse(102, 4'b0000, 4'b0010);
    push_pulse(106, 4'b0000, 4'b0010);
    push_pulse(110, 4'b0000, 4'b0010);
    buttons = 4'b0010;
    at_neg(89);
    buttons = 4'b0000;
    at_neg(91);
    buttons = 4'b0010;
    at_neg(111);
    buttons = 4'b0000;

    // All four buttons rise together.
    at_neg(129);
    push_lvl(135, 4'b0000);
    push_lvl(136, 4'b1111);
    push_lvl(160, 4'b1111);
    push_lvl(161, 4'b0000);
    push_pulse(136, 4'b1111, 4'b1111);
    push_pulse(145, 4'b0000, 4'b1111);
    push_pulse(149, 4'b0000, 4'b1111);
    push_pulse(153, 4'b0000, 4'b1111);
    buttons = 4'b1111;
    at_neg(154);
    buttons = 4'b0000;

    // One-cycle reset while bit 3 is holding; press restarts from scratch.
    at_neg(169);
    push_lvl(175, 4'b0000);
    push_lvl(176, 4'b1000);
    push_lvl(179, 4'b1000);
    push_lvl(180, 4'b0000);
    push_lvl(186, 4'b0000);
    push_lvl(187, 4'b1000);
    push_lvl(202, 4'b1000);
    push_lvl(203, 4'b0000);
    push_pulse(176, 4'b1000, 4'b1000);
    push_pulse(187, 4'b1000, 4'b1000);
    push_pulse(196, 4'b0000, 4'b1000);
    buttons = 4'b1000;
    at_neg(179);
    reset = 1'b1;
    at_neg(180);
    reset = 1'b0;
    at_neg(196);
    buttons = 4'b0000;

    at_neg(212);
    done = 1'b1;
    checks++;
    if (pq.size() != 0) begin
      failures++;
      $display("FAIL pulse_queue_drained actual=%0d required=0", pq.size());
    end
    checks++;
    if (lq.size() != 0) begin
      failures++;
      $display("FAIL level_queue_drained actual=%0d required=0", lq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
